// File: rtl/axis_latmon_pkg.sv
// Shared types and helpers for the AXI-Stream latency monitor.
package axis_latmon_pkg;

  // Storage widths of one statistics record. Module parameters select the
  // active (saturation) width and must not exceed these.
  localparam int LATMON_COUNT_W = 32;
  localparam int LATMON_TS_W    = 32;
  localparam int LATMON_SUM_W   = 48;

  localparam logic [LATMON_TS_W-1:0] LATMON_MIN_INIT = '1;

  typedef enum logic {ST_HEAD, ST_BODY} latmon_state_e;

  typedef struct packed {
    logic [LATMON_COUNT_W-1:0] count;
    logic [LATMON_TS_W-1:0]    min;
    logic [LATMON_TS_W-1:0]    max;
    logic [LATMON_SUM_W-1:0]   sum;
  } latmon_stats_t;

  // All-ones value of a w-bit field, held in 64 bits.
  function automatic logic [63:0] sat_max(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  // a + b clamped to lim (operands are assumed <= lim).
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] lim);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, lim}) ? lim : s[63:0];
  endfunction

endpackage

// File: rtl/axis_latmon_stat_cell.sv
// One source's latency statistics; saturating count/sum, running min/max.
module axis_latmon_stat_cell
  import axis_latmon_pkg::*;
#(
  parameter int TS_WIDTH    = 32,
  parameter int COUNT_WIDTH = 32,
  parameter int SUM_WIDTH   = 48
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                wr,
  input  logic [TS_WIDTH-1:0] lat,
  output latmon_stats_t       stats
);

  localparam logic [LATMON_TS_W-1:0] MIN_INIT = LATMON_MIN_INIT >> (LATMON_TS_W - TS_WIDTH);

  logic [LATMON_TS_W-1:0] lat_x;
  latmon_stats_t          nxt;

  assign lat_x = LATMON_TS_W'(lat);

  // Next record for a write: saturate at the configured widths.
  always_comb begin
    nxt       = stats;
    nxt.count = LATMON_COUNT_W'(sat_add(64'(stats.count), 64'd1, sat_max(COUNT_WIDTH)));
    nxt.sum   = LATMON_SUM_W'(sat_add(64'(stats.sum), 64'(lat_x), sat_max(SUM_WIDTH)));
    nxt.min   = (lat_x < stats.min) ? lat_x : stats.min;
    nxt.max   = (lat_x > stats.max) ? lat_x : stats.max;
  end

  // Record register; min starts at all-ones so the first sample always wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      stats.count <= '0;
      stats.min   <= MIN_INIT;
      stats.max   <= '0;
      stats.sum   <= '0;
    end else if (wr) begin
      stats <= nxt;
    end
  end

endmodule

// File: rtl/axis_latency_monitor.sv
// AXI-Stream sink measuring head-flit latency per source.
// Optional aggregate latency histogram: define AXIS_LATMON_HIST_EN.
module axis_latency_monitor
  import axis_latmon_pkg::*;
#(
  parameter int TDATA_WIDTH = 64,
  parameter int TID_WIDTH   = 2,
  parameter int TDEST_WIDTH = 2,
  parameter int NUM_SOURCES = 4,
  parameter int TDEST       = 0,
  parameter int TS_WIDTH    = 32,
  parameter int COUNT_WIDTH = 32,
  parameter int SUM_WIDTH   = 48
`ifdef AXIS_LATMON_HIST_EN
  ,
  parameter int HIST_BINS   = 16,
  parameter int HIST_SHIFT  = 3
`endif
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [TS_WIDTH-1:0]    ticks,
  input  logic                   axis_in_tvalid,
  output logic                   axis_in_tready,
  input  logic [TDATA_WIDTH-1:0] axis_in_tdata,
  input  logic                   axis_in_tlast,
  input  logic [TID_WIDTH-1:0]   axis_in_tid,
  input  logic [TDEST_WIDTH-1:0] axis_in_tdest,
  input  logic [TID_WIDTH-1:0]   rd_tid,
  output logic [COUNT_WIDTH-1:0] rd_count,
  output logic [TS_WIDTH-1:0]    rd_min,
  output logic [TS_WIDTH-1:0]    rd_max,
  output logic [SUM_WIDTH-1:0]   rd_sum,
  output logic [COUNT_WIDTH-1:0] total_packets,
  output logic                   error,
`ifdef AXIS_LATMON_HIST_EN
  input  logic [$clog2(HIST_BINS)-1:0] rd_bin,
  output logic [COUNT_WIDTH-1:0]       rd_hist_count,
`endif
  output logic                   busy
);

  // With a full ID space no tid can be out of range.
  localparam bit ALL_IDS = NUM_SOURCES >= (2 ** TID_WIDTH);

  latmon_state_e          state_q, state_d;
  logic [TID_WIDTH-1:0]   pkt_tid_q;
  logic                   hs, head_hs, tid_bad, err_d;
  logic [TS_WIDTH-1:0]    lat;
  logic                   s1_vld;
  logic [TID_WIDTH-1:0]   s1_tid;
  logic [TS_WIDTH-1:0]    s1_lat;
  latmon_stats_t          cell_stats [NUM_SOURCES];
  latmon_stats_t          sel;

  assign hs      = axis_in_tvalid & axis_in_tready;
  assign head_hs = hs && (state_q == ST_HEAD);
  assign tid_bad = !ALL_IDS && (int'(axis_in_tid) >= NUM_SOURCES);
  assign lat     = ticks - axis_in_tdata[TS_WIDTH-1:0];
  assign busy    = s1_vld;

  // Ready comes up one cycle after reset and then stays up.
  always_ff @(posedge clk) begin
    if (rst) axis_in_tready <= 1'b0;
    else     axis_in_tready <= 1'b1;
  end

  // Packet framing: next state and protocol error detection.
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    if (hs) begin
      if (axis_in_tdest != TDEST_WIDTH'(TDEST)) err_d = 1'b1;
      if (state_q == ST_HEAD) begin
        if (tid_bad) err_d = 1'b1;
        if (!axis_in_tlast) state_d = ST_BODY;
      end else begin
        if (axis_in_tid != pkt_tid_q) err_d = 1'b1;
        if (axis_in_tlast) state_d = ST_HEAD;
      end
    end
  end

  // Framing state, packet tid and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_HEAD;
      pkt_tid_q <= '0;
      error     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (head_hs) pkt_tid_q <= axis_in_tid;
      if (err_d)   error     <= 1'b1;
    end
  end

  // S1: capture latency of accepted, in-range head flits.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_tid <= '0;
      s1_lat <= '0;
    end else begin
      s1_vld <= head_hs && enable && !tid_bad;
      s1_tid <= axis_in_tid;
      s1_lat <= lat;
    end
  end

  // S2: one statistics record per source.
  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_src
    axis_latmon_stat_cell #(
      .TS_WIDTH    (TS_WIDTH),
      .COUNT_WIDTH (COUNT_WIDTH),
      .SUM_WIDTH   (SUM_WIDTH)
    ) u_cell (
      .clk   (clk),
      .rst   (rst),
      .wr    (s1_vld && (int'(s1_tid) == i)),
      .lat   (s1_lat),
      .stats (cell_stats[i])
    );
  end

  // Aggregate packet counter, saturating.
  always_ff @(posedge clk) begin
    if (rst)                          total_packets <= '0;
    else if (s1_vld && !(&total_packets)) total_packets <= total_packets + 1'b1;
  end

  // Read select; out-of-range tid reads as all-zero.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SOURCES; i++)
      if (int'(rd_tid) == i) sel = cell_stats[i];
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= '0;
      rd_min   <= '1;
      rd_max   <= '0;
      rd_sum   <= '0;
    end else begin
      rd_count <= COUNT_WIDTH'(sel.count);
      rd_min   <= TS_WIDTH'(sel.min);
      rd_max   <= TS_WIDTH'(sel.max);
      rd_sum   <= SUM_WIDTH'(sel.sum);
    end
  end

`ifdef AXIS_LATMON_HIST_EN
  localparam int BIN_W = $clog2(HIST_BINS);

  logic [COUNT_WIDTH-1:0] hist [HIST_BINS];
  logic [TS_WIDTH-1:0]    lat_sh;
  logic [BIN_W-1:0]       bin;

  assign lat_sh = s1_lat >> HIST_SHIFT;
  assign bin    = (lat_sh >= TS_WIDTH'(HIST_BINS - 1)) ? BIN_W'(HIST_BINS - 1) : BIN_W'(lat_sh);

  // Histogram bins over all sources, saturating, with registered read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < HIST_BINS; b++) hist[b] <= '0;
      rd_hist_count <= '0;
    end else begin
      if (s1_vld && !(&hist[bin])) hist[bin] <= hist[bin] + 1'b1;
      rd_hist_count <= hist[rd_bin];
    end
  end
`endif

endmodule

// File: tb/tb_axis_latency_monitor.sv
// Directed bench for axis_latency_monitor. SUM_WIDTH is narrowed to 34 so
// sum saturation is reachable with a handful of maximum-latency packets.
module tb_axis_latency_monitor;

  localparam int SW = 34;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [31:0] ticks = '0;
  logic        axis_in_tvalid = 1'b0;
  logic        axis_in_tready;
  logic [63:0] axis_in_tdata = '0;
  logic        axis_in_tlast = 1'b0;
  logic [1:0]  axis_in_tid = '0;
  logic [1:0]  axis_in_tdest = '0;
  logic [1:0]  rd_tid = '0;
  logic [31:0] rd_count, rd_min, rd_max;
  logic [SW-1:0] rd_sum;
  logic [31:0] total_packets;
  logic        error, busy;
`ifdef AXIS_LATMON_HIST_EN
  logic [3:0]  rd_bin = '0;
  logic [31:0] rd_hist_count;
`endif

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axis_latency_monitor #(.SUM_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ticks(ticks),
    .axis_in_tvalid(axis_in_tvalid), .axis_in_tready(axis_in_tready),
    .axis_in_tdata(axis_in_tdata), .axis_in_tlast(axis_in_tlast),
    .axis_in_tid(axis_in_tid), .axis_in_tdest(axis_in_tdest),
    .rd_tid(rd_tid), .rd_count(rd_count), .rd_min(rd_min), .rd_max(rd_max),
    .rd_sum(rd_sum), .total_packets(total_packets), .error(error),
`ifdef AXIS_LATMON_HIST_EN
    .rd_bin(rd_bin), .rd_hist_count(rd_hist_count),
`endif
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One flit; returns #1 after the accepting edge.
  task automatic send(input logic [1:0] tid, input logic [1:0] dest, input logic [31:0] ts,
                      input logic [31:0] t, input logic last);
    axis_in_tvalid = 1'b1;
    axis_in_tid    = tid;
    axis_in_tdest  = dest;
    axis_in_tdata  = {32'h0, ts};
    ticks          = t;
    axis_in_tlast  = last;
    @(posedge clk); #1;
    axis_in_tvalid = 1'b0;
  endtask

  task automatic pkt1(input logic [1:0] tid, input logic [31:0] ts, input logic [31:0] lat);
    send(tid, 2'd0, ts, ts + lat, 1'b1);
  endtask

  // 4-flit packet; body flits would look like latency 50000 if counted.
  task automatic pkt4(input logic [1:0] tid, input logic [31:0] lat);
    send(tid, 2'd0, 32'd1000, 32'd1000 + lat, 1'b0);
    send(tid, 2'd0, 32'd0, 32'd50000, 1'b0);
    send(tid, 2'd0, 32'd0, 32'd50000, 1'b0);
    send(tid, 2'd0, 32'd0, 32'd50000, 1'b1);
  endtask

  task automatic rd(input logic [1:0] tid);
    rd_tid = tid;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    axis_in_tvalid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", 64'(axis_in_tready), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_total", 64'(total_packets), 64'd0);
    chk("rst_min", 64'(rd_min), 64'hFFFF_FFFF);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("tready_up", 64'(axis_in_tready), 64'd1);

    // Single-flit packet, lat 30
    pkt1(2'd1, 32'd100, 32'd30);
    chk("busy_s1", 64'(busy), 64'd1);
    rd(2'd1);
    chk("t1_count", 64'(rd_count), 64'd1);
    chk("t1_min", 64'(rd_min), 64'd30);
    chk("t1_max", 64'(rd_max), 64'd30);
    chk("t1_sum", 64'(rd_sum), 64'd30);
    chk("t1_total", 64'(total_packets), 64'd1);
    chk("t1_error", 64'(error), 64'd0);
    rd(2'd0);
    chk("t0_empty", 64'(rd_count), 64'd0);

    // Multi-flit packets from tid 2
    pkt4(2'd2, 32'd10);
    pkt4(2'd2, 32'd5);
    pkt4(2'd2, 32'd20);
    rd(2'd2);
    chk("t2_count", 64'(rd_count), 64'd3);
    chk("t2_min", 64'(rd_min), 64'd5);
    chk("t2_max", 64'(rd_max), 64'd20);
    chk("t2_sum", 64'(rd_sum), 64'd35);

    // Timestamp wrap
    send(2'd3, 2'd0, 32'hFFFF_FFF0, 32'h10, 1'b1);
    rd(2'd3);
    chk("wrap_min", 64'(rd_min), 64'd32);
    chk("wrap_sum", 64'(rd_sum), 64'd32);

    // Sum saturation at 34 bits with maximum latency
    for (int i = 0; i < 4; i++) pkt1(2'd0, 32'd0, 32'hFFFF_FFFF);
    rd(2'd0);
    chk("sum_4max", 64'(rd_sum), 64'h3_FFFF_FFFC);
    chk("max_all1", 64'(rd_max), 64'hFFFF_FFFF);
    pkt1(2'd0, 32'd0, 32'hFFFF_FFFF);
    rd(2'd0);
    chk("sum_sat", 64'(rd_sum), 64'h3_FFFF_FFFF);
    chk("sat_count", 64'(rd_count), 64'd5);
    chk("total_10", 64'(total_packets), 64'd10);

    // enable=0: accepted but not counted
    enable = 1'b0;
    pkt1(2'd1, 32'd0, 32'd7);
    chk("dis_busy", 64'(busy), 64'd0);
    rd(2'd1);
    chk("dis_count", 64'(rd_count), 64'd1);
    chk("dis_total", 64'(total_packets), 64'd10);
    enable = 1'b1;
    chk("err_clean", 64'(error), 64'd0);

    // tid change inside a packet
    send(2'd1, 2'd0, 32'd0, 32'd1, 1'b0);
    send(2'd2, 2'd0, 32'd0, 32'd1, 1'b1);
    chk("err_tid", 64'(error), 64'd1);

    // Reset mid-packet clears stats and error
    send(2'd2, 2'd0, 32'd0, 32'd4, 1'b0);
    rd_tid = 2'd2;
    do_reset();
    rd(2'd2);
    chk("mrst_count", 64'(rd_count), 64'd0);
    chk("mrst_min", 64'(rd_min), 64'hFFFF_FFFF);
    chk("mrst_sum", 64'(rd_sum), 64'd0);
    chk("mrst_total", 64'(total_packets), 64'd0);
    chk("mrst_error", 64'(error), 64'd0);

    // Wrong tdest sets a sticky error
    send(2'd1, 2'd1, 32'd0, 32'd3, 1'b1);
    chk("err_dest", 64'(error), 64'd1);
    pkt1(2'd1, 32'd0, 32'd3);
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", 64'(error), 64'd1);

    // Back-to-back heads alternating tid 0/3
    do_reset();
    for (int i = 0; i < 1000; i++) pkt1((i % 2 == 0) ? 2'd0 : 2'd3, 32'(i), 32'd7);
    chk("b2b_busy1", 64'(busy), 64'd1);
    @(posedge clk); #1;
    chk("b2b_busy0", 64'(busy), 64'd0);
    rd(2'd0);
    chk("b2b_c0", 64'(rd_count), 64'd500);
    chk("b2b_s0", 64'(rd_sum), 64'd3500);
    rd(2'd3);
    chk("b2b_c3", 64'(rd_count), 64'd500);
    chk("b2b_total", 64'(total_packets), 64'd1000);

`ifdef AXIS_LATMON_HIST_EN
    do_reset();
    pkt1(2'd1, 32'd0, 32'd3);
    pkt1(2'd2, 32'd0, 32'd9);
    pkt1(2'd0, 32'd0, 32'd200);
    rd_bin = 4'd0;  repeat (2) @(posedge clk); #1;
    chk("hist_b0", 64'(rd_hist_count), 64'd1);
    rd_bin = 4'd1;  repeat (2) @(posedge clk); #1;
    chk("hist_b1", 64'(rd_hist_count), 64'd1);
    rd_bin = 4'd2;  repeat (2) @(posedge clk); #1;
    chk("hist_b2", 64'(rd_hist_count), 64'd0);
    rd_bin = 4'd15; repeat (2) @(posedge clk); #1;
    chk("hist_b15", 64'(rd_hist_count), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
